// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS-I integer subset core: IDLE/FETCH/DECODE/EXEC/MEM/WB.
//   Owns the PC, register file, ALU and control. Instruction and data memory
//   are reached through independent req/ack handshakes of arbitrary latency.
// Ports
//   clk, reset (async, active low)
//   imem_req/imem_addr  -> fetch request and address; imem_ack/imem_rdata <- response
//   dmem_req/dmem_we/dmem_addr/dmem_wdata -> data access; dmem_ack/dmem_rdata <- response
//   pc      current instruction address
//   retire  pulse on the final cycle of each instruction
//   illegal pulse when an undecodable instruction is discarded
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);

  localparam int NumRegs = 1 << REG_ADDR_W;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2a;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb
  } state_e;

  state_e                  r_state, w_state_d;
  logic [31:0]             r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
  logic [31:0]             r_rf [NumRegs];

  logic [5:0]              w_op, w_funct;
  logic [REG_ADDR_W-1:0]   w_rs, w_rt, w_rd, w_dest;
  logic [31:0]             w_imm, w_pc4, w_rs_val, w_rt_val, w_alu;
  logic                    w_legal;

  assign w_op     = r_ir[31:26];
  assign w_funct  = r_ir[5:0];
  assign w_rs     = r_ir[21 +: REG_ADDR_W];
  assign w_rt     = r_ir[16 +: REG_ADDR_W];
  assign w_rd     = r_ir[11 +: REG_ADDR_W];
  assign w_imm    = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_pc4    = r_pc + 32'd4;
  assign w_dest   = (w_op == OpRtype) ? w_rd : w_rt;
  // $0 is hardwired: never written, and forced to zero on read for safety.
  assign w_rs_val = (w_rs == '0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? 32'd0 : r_rf[w_rt];
  assign pc       = r_pc;

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OpRtype: w_legal = (w_funct == FnAdd) || (w_funct == FnSub) || (w_funct == FnAnd) ||
                         (w_funct == FnOr)  || (w_funct == FnSlt);
      OpJ, OpBeq, OpAddi, OpLw, OpSw: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Addi, lw and sw all use A + imm; R-type selects on funct.
  always_comb begin
    w_alu = r_a + w_imm;
    if (w_op == OpRtype) begin
      case (w_funct)
        FnAdd:   w_alu = r_a + r_b;
        FnSub:   w_alu = r_a - r_b;
        FnAnd:   w_alu = r_a & r_b;
        FnOr:    w_alu = r_a | r_b;
        FnSlt:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  // Next state and outputs. Outputs decode from r_state, which resets
  // asynchronously, so requests drop as soon as reset asserts.
  always_comb begin
    w_state_d  = r_state;
    imem_req   = 1'b0;
    imem_addr  = 32'd0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    retire     = 1'b0;
    illegal    = 1'b0;
    unique case (r_state)
      StIdle: w_state_d = StFetch;
      StFetch: begin
        imem_req  = 1'b1;
        imem_addr = r_pc;
        if (imem_ack) w_state_d = StDecode;
      end
      StDecode: begin
        if (!w_legal) begin
          illegal   = 1'b1;
          retire    = 1'b1;
          w_state_d = StFetch;
        end else if (w_op == OpJ) begin
          retire    = 1'b1;
          w_state_d = StFetch;
        end else begin
          w_state_d = StExec;
        end
      end
      StExec: begin
        if (w_op == OpBeq) begin
          retire    = 1'b1;
          w_state_d = StFetch;
        end else if ((w_op == OpLw) || (w_op == OpSw)) begin
          w_state_d = StMem;
        end else begin
          w_state_d = StWb;
        end
      end
      StMem: begin
        dmem_req   = 1'b1;
        dmem_we    = (w_op == OpSw);
        dmem_addr  = r_alu;
        dmem_wdata = r_b;
        if (dmem_ack) begin
          if (w_op == OpSw) begin
            retire    = 1'b1;
            w_state_d = StFetch;
          end else begin
            w_state_d = StWb;
          end
        end
      end
      StWb: begin
        retire    = 1'b1;
        w_state_d = StFetch;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_ir    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_alu   <= 32'd0;
      r_mdr   <= 32'd0;
      for (int i = 0; i < NumRegs; i++) r_rf[i] <= 32'd0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StFetch: if (imem_ack) r_ir <= imem_rdata;
        StDecode: begin
          r_a <= w_rs_val;
          r_b <= w_rt_val;
          if (!w_legal)          r_pc <= w_pc4;
          else if (w_op == OpJ)  r_pc <= {w_pc4[31:28], r_ir[25:0], 2'b00};
        end
        StExec: begin
          r_alu <= w_alu;
          if (w_op == OpBeq)
            r_pc <= (r_a == r_b) ? (w_pc4 + {w_imm[29:0], 2'b00}) : w_pc4;
        end
        StMem: begin
          if (dmem_ack) begin
            if (w_op == OpSw) r_pc  <= w_pc4;
            else              r_mdr <= dmem_rdata;
          end
        end
        StWb: begin
          if (w_dest != '0) r_rf[w_dest] <= (w_op == OpLw) ? r_mdr : r_alu;
          r_pc <= w_pc4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core. A directed program is loaded into
// the instruction memory model; each instruction pushes its expected retire
// (next pc, illegal flag, latency) and each store pushes its expected address
// and data. Monitors pop and compare as the core retires and accesses memory.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic        retire, illegal;

  always #5 clk = ~clk;

  mips_multicycle_core #(
    .RESET_PC   (32'h0000_0000),
    .REG_ADDR_W (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .retire     (retire),
    .illegal    (illegal)
  );

  // Memory models: ack after a programmable number of wait cycles.
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          imem_wait = 0;
  int          dmem_wait = 3;
  int          imem_cnt = 0;
  int          dmem_cnt = 0;

  assign imem_ack   = imem_req && (imem_cnt >= imem_wait);
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_ack   = dmem_req && (dmem_cnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr[9:2]];

  always @(posedge clk) begin
    imem_cnt <= (!imem_req || imem_ack) ? 0 : imem_cnt + 1;
    dmem_cnt <= (!dmem_req || dmem_ack) ? 0 : dmem_cnt + 1;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
  end

  typedef struct {
    logic [31:0] npc;
    logic        ill;
    int          lat;
  } ret_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  ret_t        q_ret [$];
  st_t         q_st  [$];
  logic [31:0] q_ld  [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          overlap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ins(input logic [31:0] a, input logic [31:0] w, input logic [31:0] npc,
                     input logic ill, input int lat);
    ret_t r;
    imem[a[9:2]] = w;
    r.npc = npc; r.ill = ill; r.lat = lat;
    q_ret.push_back(r);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    st_t s;
    s.addr = a; s.data = d;
    q_st.push_back(s);
  endtask

  // Retire monitor: latency counted from the first FETCH cycle.
  initial begin : retire_mon
    bit   in_instr = 0;
    int   lat = 0;
    ret_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_instr = 0;
      end else begin
        if (!in_instr && imem_req) begin
          in_instr = 1;
          lat = 0;
        end
        if (in_instr) lat++;
        if (illegal && !retire) chk("illegal_without_retire", 32'(illegal), 32'd0);
        if (retire) begin
          in_instr = 0;
          if (q_ret.size() == 0) begin
            chk("unexpected_retire", pc, 32'hFFFF_FFFF);
          end else begin
            e = q_ret.pop_front();
            chk("illegal_flag", 32'(illegal), 32'(e.ill));
            chk("latency", 32'(lat), 32'(e.lat));
            @(posedge clk);
            #1;
            chk("next_pc", pc, e.npc);
          end
        end
      end
    end
  end

  // Data monitor: store address/data must match and stay stable until ack.
  initial begin : data_mon
    st_t s;
    forever begin
      @(negedge clk);
      if (reset && dmem_req) begin
        if (dmem_we) begin
          if (q_st.size() == 0) begin
            chk("unexpected_store", dmem_addr, 32'hFFFF_FFFF);
          end else begin
            s = q_st[0];
            chk("st_addr", dmem_addr, s.addr);
            chk("st_wdata", dmem_wdata, s.data);
            if (dmem_ack) void'(q_st.pop_front());
          end
        end else if (dmem_ack) begin
          if (q_ld.size() == 0) chk("unexpected_load", dmem_addr, 32'hFFFF_FFFF);
          else                  chk("ld_addr", dmem_addr, q_ld.pop_front());
        end
      end
    end
  end

  always @(negedge clk) if (imem_req && dmem_req) overlap <= overlap + 1;

  initial begin : stim
    bit done;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'd0;
      dmem[i] = 32'd0;
    end
    // Arithmetic
    ins(32'h000, 32'h2001_0005, 32'h004, 1'b0, 4);  // addi $1,$0,5
    ins(32'h004, 32'h2002_FFFD, 32'h008, 1'b0, 4);  // addi $2,$0,-3
    ins(32'h008, 32'h0022_1820, 32'h00C, 1'b0, 4);  // add  $3,$1,$2 = 2
    ins(32'h00C, 32'h0041_202A, 32'h010, 1'b0, 4);  // slt  $4,$2,$1 = 1
    // Control flow
    ins(32'h010, 32'h1021_0002, 32'h01C, 1'b0, 3);  // beq $1,$1,2 taken
    ins(32'h01C, 32'h0800_0040, 32'h100, 1'b0, 2);  // j 0x40
    // Memory with 3 wait cycles on dmem
    ins(32'h100, 32'hAC01_0008, 32'h104, 1'b0, 7);  st(32'h08, 32'd5);  // sw $1,8
    ins(32'h104, 32'h8C05_0008, 32'h108, 1'b0, 8);  q_ld.push_back(32'h08);  // lw $5,8
    ins(32'h108, 32'hAC03_0010, 32'h10C, 1'b0, 7);  st(32'h10, 32'd2);  // sw $3
    ins(32'h10C, 32'hAC04_0014, 32'h110, 1'b0, 7);  st(32'h14, 32'd1);  // sw $4
    ins(32'h110, 32'hAC05_0018, 32'h114, 1'b0, 7);  st(32'h18, 32'd5);  // sw $5
    ins(32'h114, 32'h1022_0005, 32'h118, 1'b0, 3);  // beq $1,$2 not taken
    ins(32'h118, 32'h2020_0007, 32'h11C, 1'b0, 4);  // addi $0,$1,7
    ins(32'h11C, 32'h0021_0020, 32'h120, 1'b0, 4);  // add  $0,$1,$1
    ins(32'h120, 32'hFC06_0001, 32'h124, 1'b1, 2);  // opcode 0x3F
    ins(32'h124, 32'h0021_1826, 32'h128, 1'b1, 2);  // xor $3 (unsupported funct)
    ins(32'h128, 32'hAC00_001C, 32'h12C, 1'b0, 7);  st(32'h1C, 32'd0);  // sw $0
    ins(32'h12C, 32'hAC03_0020, 32'h130, 1'b0, 7);  st(32'h20, 32'd2);  // $3 untouched
    ins(32'h130, 32'h0022_3022, 32'h134, 1'b0, 4);  // sub $6 = 8
    ins(32'h134, 32'h0022_3824, 32'h138, 1'b0, 4);  // and $7 = 5
    ins(32'h138, 32'h0022_4025, 32'h13C, 1'b0, 4);  // or  $8 = -3
    ins(32'h13C, 32'h0022_482A, 32'h140, 1'b0, 4);  // slt $9,$1,$2 = 0 (signed)
    ins(32'h140, 32'hAC06_0024, 32'h144, 1'b0, 7);  st(32'h24, 32'd8);
    ins(32'h144, 32'hAC07_0028, 32'h148, 1'b0, 7);  st(32'h28, 32'd5);
    ins(32'h148, 32'hAC08_002C, 32'h14C, 1'b0, 7);  st(32'h2C, 32'hFFFF_FFFD);
    ins(32'h14C, 32'hAC09_0030, 32'h150, 1'b0, 7);  st(32'h30, 32'd0);
    // Store that is aborted by reset mid-wait: no retire expected.
    imem[32'h150 >> 2] = 32'hAC01_0040;
    st(32'h40, 32'd5);

    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("idle_imem_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_fetch_req", 32'(imem_req), 32'd1);
    chk("first_fetch_addr", imem_addr, 32'd0);

    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      #1;
      if (q_ret.size() == 0) done = 1;
    end
    if (!done) chk("program_timeout", 32'(q_ret.size()), 32'd0);

    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (dmem_req) done = 1;
    end
    chk("abort_store_reached", 32'(done), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_dmem_req", 32'(dmem_req), 32'd0);
    chk("abort_pc", pc, 32'd0);
    chk("abort_imem_req", 32'(imem_req), 32'd0);
    q_st.delete();
    @(negedge clk);
    chk("abort_dmem_req_held", 32'(dmem_req), 32'd0);
    chk("ld_queue_empty", 32'(q_ld.size()), 32'd0);
    chk("req_overlap", 32'(overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
